// File: rtl/axil_uart_pkg.sv
// Shared definitions for the AXI4-Lite UART transmitter.
//   - Register word offsets (decoded from address bits [3:2])
//   - AXI response codes
//   - Serializer state encoding
package axil_uart_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_IRQCTRL = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } ser_state_e;

endpackage

// File: rtl/axil_uart_tx_if.sv
// AXI4-Lite bus bundle for the UART transmitter.
//   master : drives AW/W/AR valid+payload, B/R ready
//   slave  : drives AW/W/AR ready, B/R valid+payload
interface axil_uart_tx_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_uart_tx_serializer.sv
// 8N1 serializer: IDLE -> START -> DATA(8 bits, LSB first) -> STOP.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   byte_valid_i/_ready_o/byte_data_i  byte handshake toward the FIFO
//   baud_div_i        bit period in clk cycles (>= 1), latched per frame
//   tx_o              registered serial line, idle high
//   busy_o            high in every state except IDLE
//   frame_done_o      high during the last cycle of a stop bit
module uart_tx_serializer
  import axil_uart_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  input  logic [15:0] baud_div_i,
  output logic        tx_o,
  output logic        busy_o,
  output logic        frame_done_o
);
  ser_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_q, div_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_q, bit_d;
  logic        tx_q, tx_d;
  logic        period_end;

  assign period_end = (cnt_q == 16'd0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_d        = div_q;
    shift_d      = shift_q;
    bit_d        = bit_q;
    byte_ready_o = 1'b0;

    unique case (state_q)
      IDLE: byte_ready_o = 1'b1;
      START: begin
        if (period_end) begin
          state_d = DATA;
          cnt_d   = div_q - 16'd1;
          bit_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (period_end) begin
          cnt_d = div_q - 16'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (period_end) begin
          // Last stop cycle: accept the next byte directly so frames run back to back.
          byte_ready_o = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Divisor is captured here so a mid-frame BAUDDIV write only affects later frames.
    if (byte_ready_o && byte_valid_i) begin
      state_d = START;
      shift_d = byte_data_i;
      div_d   = baud_div_i;
      cnt_d   = baud_div_i - 16'd1;
    end

    // Line level follows the next state so tx_q lines up with state_q.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      div_q   <= 16'd1;
      shift_q <= 8'd0;
      bit_q   <= 3'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_o         = tx_q;
  assign busy_o       = (state_q != IDLE);
  assign frame_done_o = (state_q == STOP) && period_end;

endmodule

// File: rtl/axil_uart_tx.sv
// AXI4-Lite slave UART transmitter: TX FIFO + baud-rate serializer.
// Registers (addr[3:2]): 0 TXDATA (W), 1 STATUS (R), 2 BAUDDIV (R/W), 3 IRQCTRL/unmapped.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   s_axi        AXI4-Lite slave bundle (axil_uart_tx_if.slave)
//   uart_tx      serial output, idle high
//   irq          interrupt (only when AXIL_UART_TX_IRQ_EN is defined)
// Optional feature macro: AXIL_UART_TX_IRQ_EN adds IRQCTRL at 0xC and the irq port.
module axil_uart_tx
  import axil_uart_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int BAUD_DIV_RST = 868
) (
  input  logic          clk,
  input  logic          reset,
  axil_uart_tx_if.slave s_axi,
  output logic          uart_tx
`ifdef AXIL_UART_TX_IRQ_EN
  ,
  output logic          irq
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [7:0]       fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [31:0]      level_ext;
  logic [3:0]       level_sat;
  logic [31:0]      status_word;

  logic [15:0] baud_q, baud_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        rvalid_q, rvalid_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        wr_hs, rd_hs;
  logic [1:0]  wr_reg, rd_reg;

  logic        ser_ready, ser_busy, ser_frame_done;

`ifdef AXIL_UART_TX_IRQ_EN
  logic irq_en_q, irq_en_d, irq_pend_q, irq_pend_d, irq_q;
`endif

  assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign fifo_pop   = ser_ready && !fifo_empty;
  assign level_ext  = 32'(level_q);
  assign level_sat  = (level_ext > 32'd15) ? 4'hF : level_ext[3:0];
  assign status_word = {24'd0, level_sat, 1'b0, fifo_empty, fifo_full, ser_busy};

  // AW and W are only ever accepted together; ready is held low in reset.
  assign wr_hs  = s_axi.awvalid && s_axi.wvalid && !bvalid_q && !reset;
  assign rd_hs  = s_axi.arvalid && !rvalid_q && !reset;
  assign wr_reg = s_axi.awaddr[3:2];
  assign rd_reg = s_axi.araddr[3:2];

  always_comb begin
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    baud_d    = baud_q;
    fifo_push = 1'b0;
    if (bvalid_q && s_axi.bready) bvalid_d = 1'b0;
    if (wr_hs) begin
      bvalid_d = 1'b1;
      bresp_d  = RESP_OKAY;
      case (wr_reg)
        REG_TXDATA: begin
          // Full is sampled before any same-cycle pop, so a push into a full FIFO is dropped.
          if (s_axi.wstrb[0]) begin
            if (fifo_full) bresp_d = RESP_SLVERR;
            else           fifo_push = 1'b1;
          end
        end
        REG_STATUS: bresp_d = RESP_OKAY;
        REG_BAUDDIV: begin
          // Lane 0 gates the whole 16-bit divisor; zero would stall the counter.
          if (s_axi.wstrb[0])
            baud_d = (s_axi.wdata[15:0] == 16'd0) ? 16'd1 : s_axi.wdata[15:0];
        end
        default: begin
`ifdef AXIL_UART_TX_IRQ_EN
          bresp_d = RESP_OKAY;
`else
          bresp_d = RESP_SLVERR;
`endif
        end
      endcase
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (rvalid_q && s_axi.rready) rvalid_d = 1'b0;
    if (rd_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_OKAY;
      rdata_d  = 32'd0;
      case (rd_reg)
        REG_TXDATA:  rdata_d = 32'd0;
        REG_STATUS:  rdata_d = status_word;
        REG_BAUDDIV: rdata_d = {16'd0, baud_q};
        default: begin
`ifdef AXIL_UART_TX_IRQ_EN
          rdata_d = {30'd0, irq_pend_q, irq_en_q};
`else
          rresp_d = RESP_SLVERR;
`endif
        end
      endcase
    end
  end

  // Storage has no reset; the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem_q[wr_ptr_q] <= s_axi.wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      baud_q   <= 16'(BAUD_DIV_RST);
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= 32'd0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      baud_q   <= baud_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end

  // The serializer latches the head byte in the same cycle it pops, so the
  // head entry is read combinationally from the small FIFO array.
  uart_tx_serializer u_ser (
    .clk          (clk),
    .reset        (reset),
    .byte_valid_i (!fifo_empty),
    .byte_data_i  (fifo_mem_q[rd_ptr_q]),
    .byte_ready_o (ser_ready),
    .baud_div_i   (baud_q),
    .tx_o         (uart_tx),
    .busy_o       (ser_busy),
    .frame_done_o (ser_frame_done)
  );

`ifdef AXIL_UART_TX_IRQ_EN
  always_comb begin
    irq_en_d   = irq_en_q;
    irq_pend_d = irq_pend_q;
    if (wr_hs && (wr_reg == REG_IRQCTRL) && s_axi.wstrb[0]) begin
      irq_en_d = s_axi.wdata[0];
      if (s_axi.wdata[1]) irq_pend_d = 1'b0;
    end
    // Serializer drops to IDLE with nothing queued: a set beats a same-cycle clear.
    if (ser_frame_done && fifo_empty) irq_pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en_q   <= 1'b0;
      irq_pend_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      irq_en_q   <= irq_en_d;
      irq_pend_q <= irq_pend_d;
      irq_q      <= irq_en_d & irq_pend_d;
    end
  end

  assign irq = irq_q;
`else
  logic unused_frame_done;
  assign unused_frame_done = ser_frame_done;
`endif

  logic unused_bits;
  assign unused_bits = ^{s_axi.awaddr[31:4], s_axi.awaddr[1:0], s_axi.araddr[31:4],
                         s_axi.araddr[1:0], s_axi.wdata[31:16], s_axi.wstrb[3:1]};

  assign s_axi.awready = wr_hs;
  assign s_axi.wready  = wr_hs;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = rd_hs;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;

endmodule

// File: tb/tb_axil_uart_tx.sv
// Self-checking bench for axil_uart_tx: AXI B/R responses and UART frames are
// predicted into queues when stimulus is issued and compared when they appear.
module tb_axil_uart_tx;
  import axil_uart_pkg::*;

  localparam logic [31:0] A_TXDATA  = 32'h0;
  localparam logic [31:0] A_STATUS  = 32'h4;
  localparam logic [31:0] A_BAUDDIV = 32'h8;
  localparam logic [31:0] A_REG_C   = 32'hC;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
  } tx_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_tx;
`ifdef AXIL_UART_TX_IRQ_EN
  logic irq;
`endif

  axil_uart_tx_if bus ();

  axil_uart_tx dut (
    .clk     (clk),
    .reset   (rst),
    .s_axi   (bus),
    .uart_tx (uart_tx)
`ifdef AXIL_UART_TX_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  tx_exp_t     exp_tx[$];
  logic [15:0] model_div = 16'd868;
  int          busy_run = 0;
  int          last_busy_run = 0;

  task automatic check_eq(input string tag, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_checks++;
    if (act_v === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act_v, exp_v);
  endtask

  task automatic start_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] resp);
    tx_exp_t e;
    exp_b.push_back(resp);
    if (addr[3:2] == 2'd0 && strb[0] && resp == RESP_OKAY) begin
      e.data = data[7:0];
      e.div  = model_div;
      exp_tx.push_back(e);
    end
    if (addr[3:2] == 2'd2 && strb[0]) model_div = (data[15:0] == 16'd0) ? 16'd1 : data[15:0];
    bus.awaddr  = addr;
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
  endtask

  task automatic wait_w_accept();
    int n = 0;
    @(negedge clk);
    while (!(bus.awready && bus.wready) && n < 200) begin @(negedge clk); n++; end
    check_eq("aw_w_accept", 32'(bus.awready && bus.wready), 32'(1));
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
  endtask

  task automatic wait_b();
    int n = 0;
    logic [1:0] e;
    @(negedge clk);
    while (!(bus.bvalid && bus.bready) && n < 200) begin @(negedge clk); n++; end
    check_eq("b_seen", 32'(bus.bvalid), 32'(1));
    e = exp_b.pop_front();
    check_eq("bresp", 32'(bus.bresp), 32'(e));
    $display("write addr=0x%0h data=0x%0h bresp=%0d", bus.awaddr, bus.wdata, bus.bresp);
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp);
    start_write(addr, data, strb, resp);
    wait_w_accept();
    wait_b();
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp);
    int n = 0;
    logic [33:0] e;
    exp_r.push_back({exp_resp, exp_data});
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    @(negedge clk);
    while (!bus.arready && n < 200) begin @(negedge clk); n++; end
    check_eq("ar_accept", 32'(bus.arready), 32'(1));
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.rvalid && n < 200) begin @(negedge clk); n++; end
    check_eq("r_seen", 32'(bus.rvalid), 32'(1));
    e = exp_r.pop_front();
    check_eq("rdata", bus.rdata, e[31:0]);
    check_eq("rresp", 32'(bus.rresp), 32'(e[33:32]));
    $display("read addr=0x%0h rdata=0x%0h rresp=%0d", addr, bus.rdata, bus.rresp);
    @(posedge clk); #1;
  endtask

  task automatic wait_tx_idle(input int max_cycles);
    int n = 0;
    while ((exp_tx.size() != 0 || dut.u_ser.busy_o) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check_eq("tx_drained", 32'(exp_tx.size()), 32'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.arvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exp_b.delete();
    exp_r.delete();
    exp_tx.delete();
    model_div = 16'd868;
  endtask

  // Busy run-length tracker for frame duration checks.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) busy_run = 0;
      else if (dut.u_ser.busy_o) busy_run++;
      else if (busy_run != 0) begin
        last_busy_run = busy_run;
        busy_run = 0;
      end
    end
  end

  // UART monitor: captures every cycle of a frame, checks levels and bit widths.
  initial begin
    tx_exp_t    e;
    logic [9:0] frame;
    bit         aborted;
    bit         glitch;
    int         div;
    int         s;
    int         k;
    forever begin
      @(negedge clk);
      if (!rst && uart_tx === 1'b0) begin
        check_eq("tx_frame_expected", 32'(exp_tx.size() != 0), 32'(1));
        if (exp_tx.size() == 0) begin
          while (uart_tx === 1'b0 && !rst) @(negedge clk);
        end else begin
          e = exp_tx[0];
          div = int'(e.div);
          s = 0;
          aborted = 1'b0;
          glitch = 1'b0;
          frame = '0;
          while (s < 10 * div && !aborted) begin
            if (s != 0) @(negedge clk);
            if (rst) aborted = 1'b1;
            else begin
              k = s / div;
              if (s % div == 0) frame[k] = uart_tx;
              else if (uart_tx !== frame[k]) glitch = 1'b1;
              s++;
            end
          end
          if (!aborted) begin
            e = exp_tx.pop_front();
            check_eq("tx_frame", 32'(frame), 32'({1'b1, e.data, 1'b0}));
            check_eq("tx_bit_width", 32'(glitch), 32'(0));
            $display("uart frame byte=0x%02h div=%0d line=%b", e.data, div, frame);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int early;
    bus.awaddr  = '0;
    bus.awvalid = 1'b0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b1;
    bus.araddr  = '0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    do_reset();

    // Reset state
    @(negedge clk);
    check_eq("rst_uart_tx", 32'(uart_tx), 32'(1));
    check_eq("rst_bvalid", 32'(bus.bvalid), 32'(0));
    check_eq("rst_rvalid", 32'(bus.rvalid), 32'(0));
    check_eq("rst_awready", 32'(bus.awready), 32'(0));
    check_eq("rst_arready", 32'(bus.arready), 32'(0));
    @(posedge clk); #1;
    axi_read(A_STATUS, 32'h04, RESP_OKAY);
    axi_read(A_BAUDDIV, 32'd868, RESP_OKAY);
    axi_read(A_TXDATA, 32'h0, RESP_OKAY);

    // Divisor: zero stored as one, lane 0 gates updates
    axi_write(A_BAUDDIV, 32'd0, 4'hF, RESP_OKAY);
    axi_read(A_BAUDDIV, 32'd1, RESP_OKAY);
    axi_write(A_BAUDDIV, 32'd4, 4'hE, RESP_OKAY);
    axi_read(A_BAUDDIV, 32'd1, RESP_OKAY);
    axi_write(A_BAUDDIV, 32'd4, 4'hF, RESP_OKAY);
    axi_read(A_BAUDDIV, 32'd4, RESP_OKAY);

    // Single frame at divisor 4
    axi_write(A_TXDATA, 32'hA5, 4'hF, RESP_OKAY);
    axi_read(A_STATUS, 32'h05, RESP_OKAY);
    wait_tx_idle(200);
    repeat (2) @(negedge clk);
    check_eq("busy_cycles", 32'(last_busy_run), 32'(40));
    @(posedge clk); #1;

`ifdef AXIL_UART_TX_IRQ_EN
    axi_write(A_REG_C, 32'h3, 4'hF, RESP_OKAY);
    @(negedge clk);
    check_eq("irq_after_clear", 32'(irq), 32'(0));
    @(posedge clk); #1;
    axi_write(A_TXDATA, 32'h3C, 4'hF, RESP_OKAY);
    wait_tx_idle(200);
    check_eq("irq_after_stop", 32'(irq), 32'(1));
    @(posedge clk); #1;
    axi_write(A_REG_C, 32'h2, 4'hF, RESP_OKAY);
    @(negedge clk);
    check_eq("irq_cleared", 32'(irq), 32'(0));
    @(posedge clk); #1;
    axi_read(A_REG_C, 32'h0, RESP_OKAY);
`else
    axi_read(A_REG_C, 32'h0, RESP_SLVERR);
    axi_write(A_REG_C, 32'h1, 4'hF, RESP_SLVERR);
`endif

    // AW ahead of W, then a held B response stalling the next write
    start_write(A_STATUS, 32'h0, 4'hF, RESP_OKAY);
    bus.wvalid = 1'b0;
    early = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.awready) early++;
    end
    check_eq("aw_waits_for_w", 32'(early), 32'(0));
    @(posedge clk); #1;
    bus.wvalid = 1'b1;
    bus.bready = 1'b0;
    wait_w_accept();
    start_write(A_BAUDDIV, 32'd4, 4'hF, RESP_OKAY);
    repeat (3) begin
      @(negedge clk);
      check_eq("bvalid_held", 32'(bus.bvalid), 32'(1));
      check_eq("write_stalled", 32'(bus.awready), 32'(0));
    end
    @(posedge clk); #1;
    bus.bready = 1'b1;
    wait_b();
    wait_w_accept();
    wait_b();

    // Fill: one byte drains into the serializer, eight fill the FIFO
    axi_write(A_BAUDDIV, 32'd1000, 4'hF, RESP_OKAY);
    for (int i = 0; i < 9; i++) axi_write(A_TXDATA, 32'h30 + 32'(i), 4'hF, RESP_OKAY);
    axi_read(A_STATUS, 32'h83, RESP_OKAY);
    axi_write(A_TXDATA, 32'h99, 4'hF, RESP_SLVERR);
    axi_read(A_STATUS, 32'h83, RESP_OKAY);
    do_reset();
    axi_read(A_STATUS, 32'h04, RESP_OKAY);

    // Reset in the middle of data bit 3 of 0x55
    axi_write(A_BAUDDIV, 32'd4, 4'hF, RESP_OKAY);
    axi_write(A_TXDATA, 32'h55, 4'hF, RESP_OKAY);
    n = 0;
    @(negedge clk);
    while (uart_tx !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    check_eq("start_bit_seen", 32'(uart_tx), 32'(0));
    repeat (17) @(negedge clk);
    check_eq("data_bit3_level", 32'(uart_tx), 32'(0));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check_eq("midframe_rst_tx", 32'(uart_tx), 32'(1));
    rst = 1'b0;
    exp_tx.delete();
    model_div = 16'd868;
    axi_read(A_STATUS, 32'h04, RESP_OKAY);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
